blink_sequencer: RTL

//   Owns the 16-bit count and mask that drive the blinker compare ((count & mask) == mask).

---
 rtl/blink_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/blink_sequencer.sv
// blink_sequencer: steps a blinker through a programmable table of mask slots.
// Each slot's mask is held for a programmed number of blink rising edges.
// Slots whose mask is zero are skipped during LOAD. The slot index wraps modulo NUM_SLOTS.
// Every output is registered, so no combinational path runs from blink_in to the outputs.
module blink_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = 16,
  parameter int REP_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]             cfg_mask,
  input  logic [REP_W-1:0]             cfg_reps,
  input  logic                         blink_in,
  output logic [CNT_W-1:0]             count,
  output logic [CNT_W-1:0]             mask,
  output logic [$clog2(NUM_SLOTS)-1:0] slot,
  output logic                         busy,
  output logic                         wrap_pulse
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [CNT_W-1:0] RST_MASK = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_r;
  logic [REP_W-1:0]   rep_cnt_r;
  logic               blink_prev_r;
  logic [CNT_W-1:0]   tbl_mask_r [NUM_SLOTS];
  logic [REP_W-1:0]   tbl_reps_r [NUM_SLOTS];

  logic [CNT_W-1:0]   cur_mask_s;
  logic [REP_W-1:0]   cur_reps_s;
  logic [REP_W-1:0]   eff_reps_s;
  logic               reps_done_s;
  logic               edge_s;
  logic [SLOT_W-1:0]  next_slot_s;
  logic               slot_wraps_s;

  // Decode the active slot entry, the rising edge and the slot-advance helpers.
  always_comb begin
    cur_mask_s   = tbl_mask_r[slot];
    cur_reps_s   = tbl_reps_r[slot];
    eff_reps_s   = cur_reps_s;
    if (cur_reps_s == {REP_W{1'b0}}) begin
      eff_reps_s = REP_W'(1);
    end else begin
      eff_reps_s = cur_reps_s;
    end
    reps_done_s  = (({1'b0, rep_cnt_r} + {{REP_W{1'b0}}, 1'b1}) >= {1'b0, eff_reps_s});
    edge_s       = blink_in & ~blink_prev_r;
    next_slot_s  = slot + SLOT_W'(1);
    slot_wraps_s = (slot == SLOT_W'(NUM_SLOTS - 1));
  end

  // Slot table storage: written from the config pins whenever the clock is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tbl_mask_r[i] <= RST_MASK;
        tbl_reps_r[i] <= REP_W'(1);
      end
    end else if (ena && cfg_we) begin
      tbl_mask_r[cfg_addr] <= cfg_mask;
      tbl_reps_r[cfg_addr] <= cfg_reps;
    end
  end

  // Sequencer FSM with registered outputs. Stop takes priority over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      count        <= {CNT_W{1'b0}};
      mask         <= {CNT_W{1'b0}};
      slot         <= {SLOT_W{1'b0}};
      busy         <= 1'b0;
      wrap_pulse   <= 1'b0;
      rep_cnt_r    <= {REP_W{1'b0}};
      blink_prev_r <= 1'b0;
    end else if (ena) begin
      wrap_pulse <= 1'b0;
      if (stop) begin
        state_r      <= ST_IDLE;
        count        <= {CNT_W{1'b0}};
        mask         <= {CNT_W{1'b0}};
        slot         <= {SLOT_W{1'b0}};
        busy         <= 1'b0;
        rep_cnt_r    <= {REP_W{1'b0}};
        blink_prev_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            count <= {CNT_W{1'b0}};
            mask  <= {CNT_W{1'b0}};
            slot  <= {SLOT_W{1'b0}};
            if (start) begin
              state_r <= ST_LOAD;
              busy    <= 1'b1;
            end
          end
          ST_LOAD: begin
            count        <= {CNT_W{1'b0}};
            rep_cnt_r    <= {REP_W{1'b0}};
            // Treat the first RUN cycle as if the blinker were already high, so it cannot count as an edge.
            blink_prev_r <= 1'b1;
            if (cur_mask_s == {CNT_W{1'b0}}) begin
              slot       <= next_slot_s;
              wrap_pulse <= slot_wraps_s;
            end else begin
              mask    <= cur_mask_s;
              state_r <= ST_RUN;
            end
          end
          ST_RUN: begin
            blink_prev_r <= blink_in;
            if (edge_s && reps_done_s) begin
              count      <= {CNT_W{1'b0}};
              slot       <= next_slot_s;
              wrap_pulse <= slot_wraps_s;
              state_r    <= ST_LOAD;
            end else begin
              count <= count + CNT_W'(1);
              if (edge_s) begin
                rep_cnt_r <= rep_cnt_r + REP_W'(1);
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            count   <= {CNT_W{1'b0}};
            mask    <= {CNT_W{1'b0}};
            slot    <= {SLOT_W{1'b0}};
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
